// File: rtl/alu_stream_unit_if.sv
// Command/response bundle between a requester and alu_stream_unit.
// The requester holds the master modport and the unit holds the slave modport.
interface alu_stream_unit_if #(
    parameter int TAG_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [31:0]      cmd_a;
    logic [31:0]      cmd_b;
    logic [2:0]       cmd_aluop;
    logic [TAG_W-1:0] cmd_tag;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_r;
    logic             rsp_c;
    logic             rsp_v;
    logic             rsp_err;
    logic [TAG_W-1:0] rsp_tag;

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_aluop, cmd_tag, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_r, rsp_c, rsp_v, rsp_err, rsp_tag
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_aluop, cmd_tag, rsp_ready,
        output cmd_ready, rsp_valid, rsp_r, rsp_c, rsp_v, rsp_err, rsp_tag
    );
endinterface

// File: rtl/alu_stream_unit.sv
// alu_32bit: combinational 32-bit ALU (AND, OR, ADD, SUB, SLT) with flags.
// alu_stream_unit: valid/ready front end that evaluates commands through one
// alu_32bit, queues results in a small FIFO and keeps saturating statistics.

module alu_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  aluop,
    output logic [31:0] r,
    output logic        c,
    output logic        v,
    output logic        err
);
    logic [32:0] sum;
    logic [31:0] b_inv;

    assign b_inv = ~b;

    // Decode the opcode; subtraction reuses the adder as a + ~b + 1 so the
    // carry is the true carry out of that sum (1 means no borrow).
    always_comb begin
        r   = 32'd0;
        c   = 1'b0;
        v   = 1'b0;
        err = 1'b0;
        sum = 33'd0;
        case (aluop)
            3'b000: r = a & b;
            3'b001: r = a | b;
            3'b010: begin
                sum = {1'b0, a} + {1'b0, b};
                r   = sum[31:0];
                c   = sum[32];
                v   = (a[31] == b[31]) && (sum[31] != a[31]);
            end
            3'b110: begin
                sum = {1'b0, a} + {1'b0, b_inv} + 33'd1;
                r   = sum[31:0];
                c   = sum[32];
                v   = (a[31] != b[31]) && (sum[31] != a[31]);
            end
            3'b111: r = {31'd0, $signed(a) < $signed(b)};
            default: err = 1'b1;
        endcase
    end
endmodule

module alu_stream_unit #(
    parameter int FIFO_DEPTH = 2,   // power of two, at least 2
    parameter int TAG_W      = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_stream_unit_if.slave  bus,
    output logic [CNT_W-1:0]  op_count,
    output logic [CNT_W-1:0]  ovf_count,
    output logic              busy
);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W = 32 + 3 + TAG_W;
    localparam logic [PTR_W:0] FULL_COUNT = FIFO_DEPTH[PTR_W:0];

    logic [31:0]        alu_r;
    logic               alu_c;
    logic               alu_v;
    logic               alu_err;

    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [ENTRY_W-1:0] head;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     count;
    logic               push;
    logic               pop;
    logic               not_empty;

    alu_32bit u_alu (
        .a     (bus.cmd_a),
        .b     (bus.cmd_b),
        .aluop (bus.cmd_aluop),
        .r     (alu_r),
        .c     (alu_c),
        .v     (alu_v),
        .err   (alu_err)
    );

    // Ready depends only on occupancy, so a full FIFO stays closed even while
    // its head is being popped; the freed slot shows up the following cycle.
    assign not_empty     = (count != '0);
    assign bus.cmd_ready = (count != FULL_COUNT);
    assign push          = bus.cmd_valid && bus.cmd_ready;
    assign pop           = not_empty && bus.rsp_ready;
    assign busy          = not_empty;
    assign head          = mem[rd_ptr];

    // Response fields are forced to zero whenever nothing is buffered.
    assign bus.rsp_valid = not_empty;
    assign bus.rsp_r     = not_empty ? head[ENTRY_W-1 -: 32] : 32'd0;
    assign bus.rsp_c     = not_empty ? head[TAG_W+2]         : 1'b0;
    assign bus.rsp_v     = not_empty ? head[TAG_W+1]         : 1'b0;
    assign bus.rsp_err   = not_empty ? head[TAG_W]           : 1'b0;
    assign bus.rsp_tag   = not_empty ? head[TAG_W-1:0]       : '0;

    // Result storage needs no reset: entries are only visible through count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {alu_r, alu_c, alu_v, alu_err, bus.cmd_tag};
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Statistics saturate at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count  <= '0;
            ovf_count <= '0;
        end else if (push) begin
            if (op_count != '1) begin
                op_count <= op_count + 1'b1;
            end
            if (alu_v && (ovf_count != '1)) begin
                ovf_count <= ovf_count + 1'b1;
            end
        end
    end
endmodule
